// File: rtl/spi_cmd_ctrl_if.sv
// Host-byte and bus-side signal bundle for the SPI command sequencer.
// The master modport belongs to the sequencer. The slave modport belongs to the SPI byte block and arbiter side.
interface spi_cmd_ctrl_if #(parameter int ADDR_WIDTH = 17);
  logic                  spi_cs_n;
  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic [7:0]            tx_byte;
  logic                  spi_ready;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wr_data;
  logic                  bus_ack;
  logic [7:0]            bus_rd_data;
  logic                  overrun;

  modport master (
    input  spi_cs_n, rx_byte, rx_valid, bus_ack, bus_rd_data,
    output tx_byte, spi_ready, bus_req, bus_we, bus_addr, bus_wr_data, overrun
  );

  modport slave (
    output spi_cs_n, rx_byte, rx_valid, bus_ack, bus_rd_data,
    input  tx_byte, spi_ready, bus_req, bus_we, bus_addr, bus_wr_data, overrun
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns host byte frames into single PET bus read/write cycles.
// It also holds the most recent read result for the next SPI byte.
module spi_cmd_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic            sys_clk,
  input  logic            sys_reset_n,
  spi_cmd_ctrl_if.master  ctl
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, BUS, DONE} state_t;

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_READ       = 2'b01;
  localparam logic [1:0] OP_WRITE_NEXT = 2'b10;

  state_t                state;
  logic                  cs_n_p0;
  logic                  cs_n_s;
  logic [1:0]            op;
  logic                  a16;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign next_addr = last_addr + ADDR_WIDTH'(1);

  function automatic logic [ADDR_WIDTH-1:0] full_addr(input logic hi_bit,
                                                      input logic [7:0] hi,
                                                      input logic [7:0] lo);
    return ADDR_WIDTH'({hi_bit, hi, lo});
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      cs_n_p0         <= 1'b1;
      cs_n_s          <= 1'b1;
      state           <= IDLE;
      op              <= OP_WRITE;
      a16             <= 1'b0;
      addr_hi         <= 8'h00;
      last_addr       <= '0;
      ctl.bus_req     <= 1'b0;
      ctl.bus_we      <= 1'b0;
      ctl.bus_addr    <= '0;
      ctl.bus_wr_data <= 8'h00;
      ctl.tx_byte     <= 8'h00;
      ctl.spi_ready   <= 1'b1;
      ctl.overrun     <= 1'b0;
    end else begin
      cs_n_p0 <= ctl.spi_cs_n;
      cs_n_s  <= cs_n_p0;
      case (state)
        IDLE: begin
          if (!cs_n_s && ctl.rx_valid) begin
            op  <= ctl.rx_byte[7:6];
            a16 <= ctl.rx_byte[0];
            case (ctl.rx_byte[7:6])
              OP_WRITE, OP_READ: state <= ADDR_HI;
              OP_WRITE_NEXT: begin
                ctl.bus_addr <= next_addr;
                state        <= DATA;
              end
              default: begin
                // READ_NEXT is complete with the command byte alone
                ctl.bus_addr  <= next_addr;
                ctl.bus_we    <= 1'b0;
                ctl.bus_req   <= 1'b1;
                ctl.spi_ready <= 1'b0;
                last_addr     <= next_addr;
                state         <= BUS;
              end
            endcase
          end
        end
        ADDR_HI: begin
          if (cs_n_s) begin
            state <= IDLE;
          end else if (ctl.rx_valid) begin
            addr_hi <= ctl.rx_byte;
            state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (cs_n_s) begin
            state <= IDLE;
          end else if (ctl.rx_valid) begin
            ctl.bus_addr <= full_addr(a16, addr_hi, ctl.rx_byte);
            if (op == OP_WRITE) begin
              state <= DATA;
            end else begin
              ctl.bus_we    <= 1'b0;
              ctl.bus_req   <= 1'b1;
              ctl.spi_ready <= 1'b0;
              last_addr     <= full_addr(a16, addr_hi, ctl.rx_byte);
              state         <= BUS;
            end
          end
        end
        DATA: begin
          if (cs_n_s) begin
            state <= IDLE;
          end else if (ctl.rx_valid) begin
            ctl.bus_wr_data <= ctl.rx_byte;
            ctl.bus_we      <= 1'b1;
            ctl.bus_req     <= 1'b1;
            ctl.spi_ready   <= 1'b0;
            last_addr       <= ctl.bus_addr;
            state           <= BUS;
          end
        end
        BUS: begin
          // Chip select is ignored here: a started bus cycle always runs to its ack
          if (ctl.rx_valid) ctl.overrun <= 1'b1;
          if (ctl.bus_ack) begin
            ctl.bus_req   <= 1'b0;
            ctl.spi_ready <= 1'b1;
            if (!ctl.bus_we) ctl.tx_byte <= ctl.bus_rd_data;
            state <= DONE;
          end
        end
        DONE: begin
          if (cs_n_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomized frame-level bench for spi_cmd_ctrl.
// A transaction model predicts the bus cycles, tx_byte and overrun, and the outputs are compared every cycle.
module tb_spi_cmd_ctrl;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_ctrl_if #(.ADDR_WIDTH(AW)) ifc ();

  spi_cmd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .sys_clk     (clk),
    .sys_reset_n (rst_n),
    .ctl         (ifc.master)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Transaction-level model state
  logic          exp_req  = 1'b0;
  logic          exp_we   = 1'b0;
  logic          exp_ovr  = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] mlast    = '0;
  logic [7:0]    exp_data = 8'h00;
  logic [7:0]    exp_tx   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("spi_ready", ifc.spi_ready, !exp_req);
      chk("bus_req", ifc.bus_req, exp_req);
      chk("tx_byte", ifc.tx_byte, exp_tx);
      chk("overrun", ifc.overrun, exp_ovr);
      if (exp_req) begin
        chk("bus_addr", ifc.bus_addr, exp_addr);
        chk("bus_we", ifc.bus_we, exp_we);
        if (exp_we) chk("bus_wr_data", ifc.bus_wr_data, exp_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ifc.rx_byte  = b;
    ifc.rx_valid = 1'b1;
    step();
    ifc.rx_valid = 1'b0;
    ifc.rx_byte  = 8'($urandom);
  endtask

  task automatic chk_reset_outs();
    chk("rst_bus_req", ifc.bus_req, 1'b0);
    chk("rst_bus_we", ifc.bus_we, 1'b0);
    chk("rst_bus_addr", ifc.bus_addr, 17'h00000);
    chk("rst_bus_wr_data", ifc.bus_wr_data, 8'h00);
    chk("rst_tx_byte", ifc.tx_byte, 8'h00);
    chk("rst_overrun", ifc.overrun, 1'b0);
    chk("rst_spi_ready", ifc.spi_ready, 1'b1);
  endtask

  // Partial frame followed by chip-select release: no bus cycle may result
  task automatic abort_frame(input logic [7:0] b0, input logic [7:0] b1, input int k);
    ifc.spi_cs_n = 1'b0;
    repeat (3) step();
    send_byte(b0);
    if (k > 1) send_byte(b1);
    ifc.spi_cs_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int ack_dly, input logic [7:0] rd,
                           input bit ovr_inj, input bit cs_in_bus, input int extra,
                           input bit rst_mid, input bit lit_en, input logic [AW-1:0] lit_addr);
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          we;
    int            n;
    logic [7:0]    bl[4];
    bl[0] = b0; bl[1] = b1; bl[2] = b2; bl[3] = b3;
    case (b0[7:6])
      2'b00:   begin n = 4; a = {b0[0], b1, b2}; d = b3;    we = 1'b1; end
      2'b01:   begin n = 3; a = {b0[0], b1, b2}; d = 8'h00; we = 1'b0; end
      2'b10:   begin n = 2; a = mlast + 17'd1;   d = b1;    we = 1'b1; end
      default: begin n = 1; a = mlast + 17'd1;   d = 8'h00; we = 1'b0; end
    endcase

    ifc.spi_cs_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < n; i++) begin
      send_byte(bl[i]);
      if (i < n - 1) repeat ($urandom_range(0, 2)) step();
    end
    exp_req  = 1'b1;
    exp_addr = a;
    exp_we   = we;
    exp_data = d;
    mlast    = a;
    if (lit_en) begin
      chk("lit_bus_addr", ifc.bus_addr, lit_addr);
      chk("lit_model_addr", a, lit_addr);
    end

    if (rst_mid) begin
      step();
      step();
      rst_n = 1'b0;
      ifc.spi_cs_n = 1'b1;
      step();
      exp_req = 1'b0;
      exp_tx  = 8'h00;
      exp_ovr = 1'b0;
      mlast   = '0;
      chk_reset_outs();
      rst_n = 1'b1;
      repeat (3) step();
      return;
    end

    for (int k = 0; k < ack_dly; k++) begin
      if (k == 0 && ovr_inj) begin
        ifc.rx_valid = 1'b1;
        ifc.rx_byte  = 8'($urandom);
      end
      if (k == 0 && cs_in_bus) ifc.spi_cs_n = 1'b1;
      step();
      if (ifc.rx_valid) exp_ovr = 1'b1;
      ifc.rx_valid = 1'b0;
    end
    ifc.bus_ack     = 1'b1;
    ifc.bus_rd_data = rd;
    if (ack_dly == 0 && ovr_inj) ifc.rx_valid = 1'b1;
    if (ack_dly == 0 && cs_in_bus) ifc.spi_cs_n = 1'b1;
    step();
    if (ifc.rx_valid) exp_ovr = 1'b1;
    ifc.rx_valid    = 1'b0;
    ifc.bus_ack     = 1'b0;
    ifc.bus_rd_data = 8'($urandom);
    exp_req = 1'b0;
    if (!we) exp_tx = rd;

    for (int e = 0; e < extra; e++) send_byte(8'($urandom));
    ifc.spi_cs_n = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    ifc.spi_cs_n    = 1'b1;
    ifc.rx_byte     = 8'h00;
    ifc.rx_valid    = 1'b0;
    ifc.bus_ack     = 1'b0;
    ifc.bus_rd_data = 8'h00;
    rst_n = 1'b0;
    step();
    chk_reset_outs();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    run_frame(8'h01, 8'h23, 8'h45, 8'hA5, 3, 8'h00, 0, 0, 0, 0, 1, 17'h12345);
    run_frame(8'h41, 8'h80, 8'h00, 8'h00, 2, 8'h5C, 0, 0, 0, 0, 1, 17'h18000);
    chk("lit_tx_read", ifc.tx_byte, 8'h5C);
    run_frame(8'hC0, 8'h00, 8'h00, 8'h00, 1, 8'h96, 0, 0, 0, 0, 1, 17'h18001);
    run_frame(8'h80, 8'h11, 8'h00, 8'h00, 2, 8'h00, 0, 0, 1, 0, 1, 17'h18002);
    chk("lit_tx_held", ifc.tx_byte, 8'h96);
    run_frame(8'h01, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 17'h1FFFF);
    run_frame(8'hC0, 8'h00, 8'h00, 8'h00, 1, 8'h3C, 0, 0, 0, 0, 1, 17'h00000);
    abort_frame(8'h01, 8'h23, 2);
    run_frame(8'h00, 8'h00, 8'h10, 8'h77, 1, 8'h00, 0, 0, 0, 0, 1, 17'h00010);
    run_frame(8'h41, 8'h12, 8'h34, 8'h00, 2, 8'hE1, 1, 0, 0, 0, 1, 17'h11234);
    chk("lit_overrun", ifc.overrun, 1'b1);
    run_frame(8'h00, 8'hAB, 8'hCD, 8'hEE, 10, 8'h00, 0, 1, 2, 0, 1, 17'h0ABCD);
    chk("lit_overrun_sticky", ifc.overrun, 1'b1);
    run_frame(8'h01, 8'h00, 8'h07, 8'h99, 5, 8'h00, 0, 0, 0, 1, 1, 17'h10007);
    run_frame(8'hC0, 8'h00, 8'h00, 8'h00, 0, 8'h42, 0, 0, 0, 0, 1, 17'h00001);
    chk("lit_tx_after_rst", ifc.tx_byte, 8'h42);

    for (int r = 0; r < 100; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        int op;
        logic [7:0] c;
        op = $urandom_range(0, 2);
        c  = 8'($urandom);
        c[7:6] = 2'(op);
        abort_frame(c, 8'($urandom), (op == 2) ? 1 : $urandom_range(1, 2));
      end else begin
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 4), 8'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 2), ($urandom_range(0, 19) == 0), 0, '0);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
